cw_bridge_master: RTL and testbench

Host-side write master for the gr-heep bridge port. It gathers byte-wide register writes from the CW305 host interface into 32-bit write commands, queues them in a small command FIFO, and issues them on the `req/we/be/addr/wdata/gnt` bridge port of `gr_heep_top`. It sits directly upstream of that bridge port. The bridge is write-only, so this block never expects read responses.

---
 rtl/cw_bridge_master_if.sv | 24 ++
 rtl/cw_bridge_master.sv | 198 +++++++++++++++++++
 tb/tb_cw_bridge_master.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cw_bridge_master_if.sv
// Host byte port and gr-heep bridge write port of cw_bridge_master.
interface cw_bridge_master_if;
  logic        host_we_i;
  logic        host_re_i;
  logic [3:0]  host_addr_i;
  logic [7:0]  host_wdata_i;
  logic [7:0]  host_rdata_o;
  logic        req_o;
  logic        we_o;
  logic [3:0]  be_o;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic        gnt_i;

  modport master (
    input  host_we_i, host_re_i, host_addr_i, host_wdata_i, gnt_i,
    output host_rdata_o, req_o, we_o, be_o, addr_o, wdata_o
  );

  modport slave (
    output host_we_i, host_re_i, host_addr_i, host_wdata_i, gnt_i,
    input  host_rdata_o, req_o, we_o, be_o, addr_o, wdata_o
  );
endinterface

// File: rtl/cw_bridge_master.sv
// Host-to-bridge write master: byte-wide staging registers, command FIFO, REQ/GNT issue FSM.
// Optional grant timeout is enabled by defining CW_BRIDGE_TIMEOUT_EN.
module cw_bridge_master #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  cw_bridge_master_if.master bus
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } cmd_t;

  typedef enum logic { IDLE = 1'b0, REQ = 1'b1 } state_t;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [31:0] stg_addr, stg_wdata;
  logic [3:0]  stg_be;
  logic        ctrl_wr, push_cmd, clr_flags;

  assign ctrl_wr   = bus.host_we_i && (bus.host_addr_i == 4'h9);
  assign push_cmd  = ctrl_wr && bus.host_wdata_i[0];
  assign clr_flags = ctrl_wr && bus.host_wdata_i[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stg_addr  <= '0;
      stg_wdata <= '0;
      stg_be    <= 4'hF;
    end else if (bus.host_we_i) begin
      case (bus.host_addr_i[3:2])
        2'b00:   stg_addr[{bus.host_addr_i[1:0], 3'b000} +: 8]  <= bus.host_wdata_i;
        2'b01:   stg_wdata[{bus.host_addr_i[1:0], 3'b000} +: 8] <= bus.host_wdata_i;
        2'b10:   if (bus.host_addr_i[1:0] == 2'b00) stg_be <= bus.host_wdata_i[3:0];
        default: ;
      endcase
    end
  end

  // Command FIFO; the head stays resident until its handshake (or timeout) pops it.
  cmd_t          mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, fill;
  logic [AW-1:0] rd_idx, nxt_idx;
  logic          fifo_empty, fifo_full, fifo_push, more_queued;
  logic          handshake, tmo_evt, advance, load_head, load_next;

  assign fill        = wr_ptr - rd_ptr;
  assign fifo_empty  = (fill == '0);
  assign fifo_full   = (fill == (AW+1)'(FIFO_DEPTH));
  assign more_queued = (fill > (AW+1)'(1));
  assign fifo_push   = push_cmd && !fifo_full;
  assign rd_idx      = rd_ptr[AW-1:0];
  assign nxt_idx     = rd_idx + AW'(1);

  always_ff @(posedge clk_i) begin
    if (fifo_push) mem[wr_ptr[AW-1:0]] <= '{addr: stg_addr, wdata: stg_wdata, be: stg_be};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (advance)   rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  state_t state, state_nxt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = REQ;
      REQ:     if (advance && !more_queued) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    handshake = 1'b0;
    load_head = 1'b0;
    case (state)
      IDLE:    load_head = !fifo_empty;
      REQ:     handshake = bus.gnt_i;
      default: ;
    endcase
    advance   = handshake || tmo_evt;
    load_next = advance && more_queued;
  end

  logic timeout_flag;

`ifdef CW_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;

  // Counts grant-less cycles of the entry currently on the bus.
  assign tmo_evt = (state == REQ) && !bus.gnt_i && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                   wait_cnt <= '0;
    else if (state != REQ || advance || load_head) wait_cnt <= '0;
    else                                           wait_cnt <= wait_cnt + TW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) timeout_flag <= 1'b0;
    else begin
      if (clr_flags) timeout_flag <= 1'b0;
      if (tmo_evt)   timeout_flag <= 1'b1;
    end
  end
`else
  assign tmo_evt      = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  logic req_q;
  cmd_t out_cmd;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q   <= 1'b0;
      out_cmd <= '0;
    end else if (load_head) begin
      req_q   <= 1'b1;
      out_cmd <= mem[rd_idx];
    end else if (load_next) begin
      out_cmd <= mem[nxt_idx];
    end else if (advance) begin
      req_q   <= 1'b0;
    end
  end

  assign bus.req_o   = req_q;
  assign bus.we_o    = req_q;
  assign bus.addr_o  = out_cmd.addr;
  assign bus.wdata_o = out_cmd.wdata;
  assign bus.be_o    = out_cmd.be;

  logic [15:0] txcnt;
  logic        overflow_flag;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      txcnt         <= '0;
      overflow_flag <= 1'b0;
    end else begin
      if (handshake) txcnt <= txcnt + 16'd1;
      // A set in the same write as a clear wins: the drop happened after the clear.
      if (clr_flags)            overflow_flag <= 1'b0;
      if (push_cmd && fifo_full) overflow_flag <= 1'b1;
    end
  end

  logic [7:0] rd_mux;

  always_comb begin
    rd_mux = 8'h00;
    case (bus.host_addr_i)
      4'h0:    rd_mux = stg_addr[7:0];
      4'h1:    rd_mux = stg_addr[15:8];
      4'h2:    rd_mux = stg_addr[23:16];
      4'h3:    rd_mux = stg_addr[31:24];
      4'h4:    rd_mux = stg_wdata[7:0];
      4'h5:    rd_mux = stg_wdata[15:8];
      4'h6:    rd_mux = stg_wdata[23:16];
      4'h7:    rd_mux = stg_wdata[31:24];
      4'h8:    rd_mux = {4'b0, stg_be};
      4'hA:    rd_mux = {4'b0, timeout_flag, overflow_flag, fifo_full, fifo_empty};
      4'hB:    rd_mux = txcnt[7:0];
      4'hC:    rd_mux = txcnt[15:8];
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)            bus.host_rdata_o <= 8'h00;
    else if (bus.host_re_i) bus.host_rdata_o <= rd_mux;
  end
endmodule

// File: tb/tb_cw_bridge_master.sv
// Bench for cw_bridge_master: queue-based reference model, per-cycle bus compare, directed + random host traffic.
module tb_cw_bridge_master;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cw_bridge_master_if bus();

  cw_bridge_master #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
  } cmd_t;

  cmd_t        q[$];
  logic [31:0] delivered[$];
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_ovf, m_tmo, m_full, m_pop;
  logic [15:0] m_txcnt;
`ifdef CW_BRIDGE_TIMEOUT_EN
  int          wait_cnt;
`endif
  int          low_wait;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    delivered.delete();
    m_addr = '0; m_wdata = '0; m_be = 4'hF;
    m_ovf = 1'b0; m_tmo = 1'b0; m_txcnt = '0;
    low_wait = 0;
`ifdef CW_BRIDGE_TIMEOUT_EN
    wait_cnt = 0;
`endif
  endtask

  function automatic logic [7:0] model_read(input logic [3:0] a);
    logic [31:0] w;
    case (a)
      4'h0, 4'h1, 4'h2, 4'h3: begin w = m_addr  >> (8 * a);       return w[7:0]; end
      4'h4, 4'h5, 4'h6, 4'h7: begin w = m_wdata >> (8 * (a - 4)); return w[7:0]; end
      4'h8: return {4'b0, m_be};
      4'hA: return {4'b0, m_tmo, m_ovf, q.size() == DEPTH, q.size() == 0};
      4'hB: return m_txcnt[7:0];
      4'hC: return m_txcnt[15:8];
      default: return 8'h00;
    endcase
  endfunction

  // Reference model: the queue holds every accepted command until the bus retires it.
  always @(posedge clk) begin
    if (rst_n) begin
      m_full = (q.size() == DEPTH);
      m_pop  = 1'b0;
      if (bus.host_we_i) begin
        if (bus.host_addr_i < 4)       m_addr[8*bus.host_addr_i +: 8]      = bus.host_wdata_i;
        else if (bus.host_addr_i < 8)  m_wdata[8*(bus.host_addr_i-4) +: 8] = bus.host_wdata_i;
        else if (bus.host_addr_i == 8) m_be = bus.host_wdata_i[3:0];
        else if (bus.host_addr_i == 9 && bus.host_wdata_i[1]) begin
          m_ovf = 1'b0; m_tmo = 1'b0;
        end
      end
      if (bus.req_o && bus.gnt_i) begin
        m_pop = 1'b1;
        m_txcnt++;
        if (q.size() > 0) delivered.push_back(q[0].d);
`ifdef CW_BRIDGE_TIMEOUT_EN
        wait_cnt = 0;
      end else if (bus.req_o) begin
        if (wait_cnt == TMO - 1) begin
          m_pop = 1'b1; m_tmo = 1'b1; wait_cnt = 0;
        end else wait_cnt++;
`endif
      end
      if (m_pop && q.size() > 0) void'(q.pop_front());
      if (bus.host_we_i && bus.host_addr_i == 9 && bus.host_wdata_i[0]) begin
        if (m_full) m_ovf = 1'b1;
        else q.push_back({m_addr, m_wdata, m_be});
      end
    end
  end

  // Bus compare: whatever is offered must be the oldest outstanding command.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("we_eq_req", {31'b0, bus.we_o}, {31'b0, bus.req_o});
      if (bus.req_o) begin
        chk("req_has_cmd", {31'b0, q.size() > 0}, 32'd1);
        if (q.size() > 0) begin
          chk("addr_o", bus.addr_o, q[0].a);
          chk("wdata_o", bus.wdata_o, q[0].d);
          chk("be_o", {28'b0, bus.be_o}, {28'b0, q[0].b});
        end
      end
      if (!bus.req_o && q.size() > 0) low_wait++;
      else low_wait = 0;
      if (low_wait > 1) chk("req_latency", {31'b0, bus.req_o}, 32'd1);
    end
  end

  task automatic hwr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.host_we_i = 1'b1; bus.host_addr_i = a; bus.host_wdata_i = d;
    @(negedge clk);
    bus.host_we_i = 1'b0;
  endtask

  task automatic hrd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.host_re_i = 1'b1; bus.host_addr_i = a;
    @(negedge clk);
    bus.host_re_i = 1'b0;
    d = bus.host_rdata_o;
  endtask

  task automatic hrd_chk(input logic [3:0] a);
    logic [7:0] exp, got;
    @(negedge clk);
    bus.host_re_i = 1'b1; bus.host_addr_i = a;
    exp = model_read(a);
    @(negedge clk);
    bus.host_re_i = 1'b0;
    got = bus.host_rdata_o;
    chk($sformatf("host_read_%0h", a), {24'b0, got}, {24'b0, exp});
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    for (int i = 0; i < 4; i++) hwr(4'(i), a[8*i +: 8]);
    for (int i = 0; i < 4; i++) hwr(4'(4 + i), d[8*i +: 8]);
    hwr(4'h8, {4'b0, b});
  endtask

  task automatic do_reset();
    bus.host_we_i = 1'b0; bus.host_re_i = 1'b0; bus.host_addr_i = '0;
    bus.host_wdata_i = '0; bus.gnt_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input int max);
    int n = 0;
    while (!bus.req_o && n < max) begin @(negedge clk); n++; end
    if (!bus.req_o) chk("wait_req_bound", 32'd0, 32'd1);
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while ((q.size() > 0 || bus.req_o) && n < max) begin @(negedge clk); n++; end
    chk("drain_bound", q.size(), 32'd0);
  endtask

  initial begin
    logic [7:0] rd;
    int n_hi, run;

    model_reset();
    do_reset();

    // reset state
    chk("rst_req", {31'b0, bus.req_o}, 32'd0);
    chk("rst_addr", bus.addr_o, 32'd0);
    hrd(4'hA, rd); chk("rst_status", {24'b0, rd}, 32'h01);
    hrd(4'h8, rd); chk("rst_be", {24'b0, rd}, 32'h0F);
    hrd(4'hB, rd); chk("rst_txcnt", {24'b0, rd}, 32'h00);

    // single write, latency t+2, one-cycle request
    prog(32'h0002_0010, 32'hDEAD_BEEF, 4'hF);
    bus.gnt_i = 1'b1;
    hwr(4'h9, 8'h01);
    chk("single_t1_low", {31'b0, bus.req_o}, 32'd0);
    @(negedge clk);
    chk("single_t2_req", {31'b0, bus.req_o}, 32'd1);
    chk("single_addr", bus.addr_o, 32'h0002_0010);
    chk("single_wdata", bus.wdata_o, 32'hDEAD_BEEF);
    chk("single_be", {28'b0, bus.be_o}, 32'hF);
    @(negedge clk);
    chk("single_one_cycle", {31'b0, bus.req_o}, 32'd0);
    bus.gnt_i = 1'b0;
    hrd(4'hB, rd); chk("single_txcnt_lo", {24'b0, rd}, 32'h01);
    hrd(4'hC, rd); chk("single_txcnt_hi", {24'b0, rd}, 32'h00);

    // stall: 10 grant-less cycles, handshake on the 11th
    do_reset();
    prog(32'h0000_0400, 32'h1234_5678, 4'h3);
    hwr(4'h9, 8'h01);
    wait_req(10);
    n_hi = 0;
    repeat (10) begin if (bus.req_o) n_hi++; @(negedge clk); end
    if (bus.req_o) n_hi++;
    bus.gnt_i = 1'b1;
    @(negedge clk);
    chk("stall_released", {31'b0, bus.req_o}, 32'd0);
    bus.gnt_i = 1'b0;
    chk("stall_req_cycles", n_hi, 32'd11);

    // overflow: fifth push dropped
    do_reset();
    prog(32'h0000_0100, 32'h0, 4'hF);
    for (int i = 1; i <= 5; i++) begin hwr(4'h4, 8'(i)); hwr(4'h9, 8'h01); end
    hrd(4'hA, rd); chk("ovf_status", {24'b0, rd}, 32'h06);
    bus.gnt_i = 1'b1;
    wait_drain(40);
    bus.gnt_i = 1'b0;
    chk("ovf_delivered_n", delivered.size(), 32'd4);
    for (int i = 0; i < 4 && i < delivered.size(); i++)
      chk("ovf_order", delivered[i], 32'(i + 1));
    hwr(4'h9, 8'h02);
    hrd(4'hA, rd); chk("ovf_cleared", {24'b0, rd}, 32'h01);

    // back-to-back
    do_reset();
    for (int i = 0; i < 3; i++) begin
      prog(32'h0000_1000 + 32'(4 * i), 32'hA0 + 32'(i), 4'(1 << i));
      hwr(4'h9, 8'h01);
    end
    wait_req(10);
    bus.gnt_i = 1'b1;
    run = 0;
    while (bus.req_o && run < 10) begin run++; @(negedge clk); end
    bus.gnt_i = 1'b0;
    chk("b2b_run", run, 32'd3);
    hrd(4'hB, rd); chk("b2b_txcnt", {24'b0, rd}, 32'h03);

`ifdef CW_BRIDGE_TIMEOUT_EN
    // timeout drops the head, second entry still delivered
    do_reset();
    prog(32'h0000_0200, 32'h11, 4'hF);
    hwr(4'h9, 8'h01);
    hwr(4'h4, 8'h22);
    hwr(4'h9, 8'h01);
    wait_req(10);
    repeat (18) @(negedge clk);
    hrd(4'hA, rd); chk("tmo_status", {24'b0, rd}, 32'h08);
    bus.gnt_i = 1'b1;
    wait_drain(40);
    bus.gnt_i = 1'b0;
    chk("tmo_delivered_n", delivered.size(), 32'd1);
    if (delivered.size() > 0) chk("tmo_delivered", delivered[0], 32'h22);
    hrd(4'hB, rd); chk("tmo_txcnt", {24'b0, rd}, 32'h01);
`endif

    // asynchronous reset in the middle of a request
    do_reset();
    for (int i = 0; i < 3; i++) begin
      prog(32'h0000_2000 + 32'(i), 32'hC0 + 32'(i), 4'hF);
      hwr(4'h9, 8'h01);
    end
    wait_req(10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_req", {31'b0, bus.req_o}, 32'd0);
    chk("async_we", {31'b0, bus.we_o}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    hrd(4'hA, rd); chk("async_status", {24'b0, rd}, 32'h01);
    hrd(4'h8, rd); chk("async_be", {24'b0, rd}, 32'h0F);

    // randomized host traffic and grant pattern
    do_reset();
    for (int it = 0; it < 400; it++) begin
      int op;
      bus.gnt_i = ($urandom_range(0, 3) != 0);
      op = $urandom_range(0, 9);
      if (op <= 3)      hwr(4'($urandom_range(0, 15)), 8'($urandom));
      else if (op <= 6) hwr(4'h9, ($urandom_range(0, 7) == 0) ? 8'h03 : 8'h01);
      else              hrd_chk(4'($urandom_range(0, 15)));
    end
    bus.gnt_i = 1'b1;
    wait_drain(64);
    bus.gnt_i = 1'b0;
    hrd_chk(4'hB);
    hrd_chk(4'hC);
    hrd_chk(4'hA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
